// File: rtl/adc_dac_pkg.sv
// Shared definitions for the ADC deserializer and DAC serializer on this board.
package adc_dac_pkg;

  // Frame geometry common to both converters.
  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = 16;

  // Receive-side FSM states.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    QUIET
  } rx_state_t;

endpackage

// File: rtl/sclk_gen.sv
// SCLK divider: while run is high, each SCLK period is CLK_DIV Clk cycles low
// followed by CLK_DIV cycles high. The first cycle of a run keeps SCLK high,
// and SCLK is held high whenever run is low.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic run,
  output logic SCLK,
  output logic rise_stb,
  output logic fall_stb,
  output logic bit_end_stb
);

  localparam int CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  // Strobes decode the divider phase. The falling edge starts a bit, the
  // rising edge is the sampling point, and bit_end marks the last cycle.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    rise_stb    = run && (cnt_q == CW'(CLK_DIV));
    fall_stb    = run && (cnt_q == '0);
    bit_end_stb = run && (cnt_q == CW'(2 * CLK_DIV - 1));
    cnt_d       = '0;
    sclk_d      = 1'b1;
    if (run) begin
      cnt_d  = bit_end_stb ? '0 : cnt_q + 1'b1;
      sclk_d = sclk_q;
      if (fall_stb) begin
        sclk_d = 1'b0;
      end else if (rise_stb) begin
        sclk_d = 1'b1;
      end
    end
  end

  // Divider counter and registered SCLK.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge values.
    if (Rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign SCLK = sclk_q;

endmodule

// File: rtl/adc_deserializer.sv
// SPI-style read master for a 12-bit serial ADC. Runs back-to-back frames
// while En is high and presents each result with a one-cycle VALID strobe.
module adc_deserializer #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = adc_dac_pkg::FRAME_BITS,
  parameter int DATA_BITS    = adc_dac_pkg::DATA_BITS,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 SDATA,
  output logic                 SCLK,
  output logic                 CSn,
  output logic [DATA_BITS-1:0] DATAOUT,
  output logic                 VALID,
  output logic                 FRAME_ERR
);

  import adc_dac_pkg::*;

  // bit counter holds the number of SCLK periods begun, 0..FRAME_BITS.
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  rx_state_t             state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [QW-1:0]         quiet_q, quiet_d;
  logic                  csn_q, csn_d;
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  logic run;
  logic rise_stb;
  logic fall_stb;
  logic bit_end_stb;

  assign run = (state_q == SHIFT);

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .Clk        (Clk),
    .Rst        (Rst),
    .run        (run),
    .SCLK       (SCLK),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .bit_end_stb(bit_end_stb)
  );

  // Next-state logic: frame sequencing, bit capture and result latching.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    quiet_d = quiet_q;
    csn_d   = csn_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        csn_d = 1'b1;
        if (En) begin
          state_d = SHIFT;
          csn_d   = 1'b0;
          bit_d   = '0;
          shreg_d = '0;
        end
      end

      SHIFT: begin
        if (fall_stb) begin
          bit_d = bit_q + 1'b1;
        end
        // SDATA is stable here: the ADC last changed it at the previous fall.
        if (rise_stb) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], SDATA};
        end
        if (bit_end_stb && (bit_q == BW'(FRAME_BITS))) begin
          state_d = QUIET;
          csn_d   = 1'b1;
          valid_d = 1'b1;
          dout_d  = shreg_q[DATA_BITS-1:0];
          ferr_d  = |shreg_q[FRAME_BITS-1:DATA_BITS];
          quiet_d = '0;
        end
      end

      QUIET: begin
        if (quiet_q == QW'(QUIET_CYCLES - 1)) begin
          if (En) begin
            state_d = SHIFT;
            csn_d   = 1'b0;
            bit_d   = '0;
            shreg_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        csn_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      // NOTE: the shift register is cleared too, so an aborted frame leaves no stale bits behind.
      shreg_q <= '0;
      quiet_q <= '0;
      csn_q   <= 1'b1;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      quiet_q <= quiet_d;
      csn_q   <= csn_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign CSn       = csn_q;
  assign DATAOUT   = dout_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_adc_deserializer.sv
// Bench for adc_deserializer: a default instance driven by a frame-queue ADC
// model, plus a CLK_DIV=2 / QUIET_CYCLES=1 instance.
module tb_adc_deserializer;

  typedef struct {
    logic [15:0] frame;
    logic [11:0] data;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        rst_a, en_a, sdata_a, sclk_a, csn_a, valid_a, ferr_a;
  logic [11:0] dout_a;
  // Instance B: fast divider, single quiet cycle.
  logic        rst_b, en_b, sdata_b, sclk_b, csn_b, valid_b, ferr_b;
  logic [11:0] dout_b;

  adc_deserializer u_dut_a (
    .Clk      (clk),
    .Rst      (rst_a),
    .En       (en_a),
    .SDATA    (sdata_a),
    .SCLK     (sclk_a),
    .CSn      (csn_a),
    .DATAOUT  (dout_a),
    .VALID    (valid_a),
    .FRAME_ERR(ferr_a)
  );

  adc_deserializer #(
    .CLK_DIV     (2),
    .QUIET_CYCLES(1)
  ) u_dut_b (
    .Clk      (clk),
    .Rst      (rst_b),
    .En       (en_b),
    .SDATA    (sdata_b),
    .SCLK     (sclk_b),
    .CSn      (csn_b),
    .DATAOUT  (dout_b),
    .VALID    (valid_b),
    .FRAME_ERR(ferr_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ADC models: a frame is loaded when CSn falls and its MSB is presented;
  // every later SCLK fall presents the next bit.
  logic [15:0] frame_q[$];
  logic [15:0] cur_a;
  int          nfall_a;
  logic [15:0] b_word = 16'h0A5A;
  int          nfall_b;
  initial begin
    sdata_a = 1'b0;
    sdata_b = 1'b0;
    cur_a   = 16'h0;
  end

  always @(negedge csn_a) begin
    cur_a   = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0;
    nfall_a = 0;
    sdata_a = cur_a[15];
  end
  always @(negedge sclk_a) begin
    if (csn_a == 1'b0) begin
      if (nfall_a < 16) sdata_a = cur_a[4'(15 - nfall_a)];
      nfall_a++;
    end
  end

  always @(negedge csn_b) begin
    nfall_b = 0;
    sdata_b = b_word[15];
  end
  always @(negedge sclk_b) begin
    if (csn_b == 1'b0) begin
      if (nfall_b < 16) sdata_b = b_word[4'(15 - nfall_b)];
      nfall_b++;
    end
  end

  // Pin monitor, sampled on the falling Clk edge.
  int          cyc = 0;
  int          a_low = 0, a_len = 0, a_rises = 0, a_rises_last = 0;
  int          a_high = 0, a_gap = 0, a_falls = 0, a_vcnt = 0, a_dbl = 0;
  int          a_vcyc = 0, a_vcyc_prev = 0;
  logic [11:0] a_data = '0;
  logic        a_err = 1'b0;
  logic        pa_csn = 1'b1, pa_sclk = 1'b1, pa_valid = 1'b0;
  int          b_low = 0, b_len = 0, b_vcnt = 0, b_vcyc = 0, b_vcyc_prev = 0;
  logic [11:0] b_data = '0;
  logic        b_err = 1'b0;
  logic        pb_csn = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (csn_a === 1'b0) begin
      if (pa_csn) begin
        a_gap   = a_high;
        a_low   = 0;
        a_rises = 0;
        a_falls++;
      end
      a_low++;
      if (sclk_a === 1'b1 && !pa_sclk) a_rises++;
    end else begin
      if (!pa_csn) a_high = 0;
      a_high++;
    end
    if (valid_a === 1'b1) begin
      if (pa_valid) a_dbl++;
      a_vcnt++;
      a_vcyc_prev  = a_vcyc;
      a_vcyc       = cyc;
      a_data       = dout_a;
      a_err        = ferr_a;
      a_len        = a_low;
      a_rises_last = a_rises;
    end
    pa_csn   = (csn_a !== 1'b0);
    pa_sclk  = (sclk_a !== 1'b0);
    pa_valid = (valid_a === 1'b1);

    if (csn_b === 1'b0) begin
      if (pb_csn) b_low = 0;
      b_low++;
    end
    if (valid_b === 1'b1) begin
      b_vcnt++;
      b_vcyc_prev = b_vcyc;
      b_vcyc      = cyc;
      b_data      = dout_b;
      b_err       = ferr_b;
      b_len       = b_low;
    end
    pb_csn = (csn_b !== 1'b0);
  end

  task automatic wait_valid_a(input string name);
    int start = a_vcnt;
    int n     = 0;
    while (a_vcnt == start && n < 400) begin
      @(posedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 32'(a_vcnt != start), 32'd1);
  endtask

  task automatic wait_rises_a(input int k, input string name);
    int n = 0;
    while (!(csn_a === 1'b0 && a_rises >= k) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check({name, "_reached"}, 32'(a_rises >= k), 32'd1);
  endtask

  task automatic wait_valid_b(input string name);
    int start = b_vcnt;
    int n     = 0;
    while (b_vcnt == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 32'(b_vcnt != start), 32'd1);
  endtask

  vec_t        tbl[6];
  logic [15:0] rnd[8];

  initial begin
    int          falls_snap;
    int          vcnt_snap;
    logic [15:0] w;

    tbl[0] = '{16'h0C93, 12'hC93, 1'b0};
    tbl[1] = '{16'h0895, 12'h895, 1'b0};
    tbl[2] = '{16'h0589, 12'h589, 1'b0};
    tbl[3] = '{16'h4FFF, 12'hFFF, 1'b1};
    tbl[4] = '{16'h0123, 12'h123, 1'b0};
    tbl[5] = '{16'h8000, 12'h000, 1'b1};

    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_csn", 32'(csn_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_dataout", 32'(dout_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    check("rst_b_csn", 32'(csn_b), 32'd1);
    check("rst_b_sclk", 32'(sclk_b), 32'd1);
    repeat (10) @(posedge clk);
    check("idle_no_frame", 32'(a_falls), 32'd0);

    // Queue table frames, random frames, then the frame used for the En drop.
    foreach (tbl[i]) frame_q.push_back(tbl[i].frame);
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) != 0) w[15:12] = 4'h0;
      rnd[i] = w;
      frame_q.push_back(w);
    end
    frame_q.push_back(16'h0ABC);

    @(posedge clk);
    #1 en_a = 1'b1;

    for (int i = 0; i < 6; i++) begin
      wait_valid_a($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_data", i), 32'(a_data), 32'(tbl[i].data));
      check($sformatf("tbl%0d_ferr", i), 32'(a_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_csn_low", i), 32'(a_len), 32'd128);
      check($sformatf("tbl%0d_rises", i), 32'(a_rises_last), 32'd16);
      if (i > 0) begin
        check($sformatf("tbl%0d_period", i), 32'(a_vcyc - a_vcyc_prev), 32'd136);
        check($sformatf("tbl%0d_gap", i), 32'(a_gap), 32'd8);
      end
    end

    // Random frames: the result is the frame modulo 4096, and the error flag
    // is set whenever the frame value reaches 4096.
    for (int i = 0; i < 8; i++) begin
      wait_valid_a($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_data", i), 32'(a_data), 32'(rnd[i]) % 32'd4096);
      check($sformatf("rnd%0d_ferr", i), 32'(a_err), 32'(rnd[i] >= 16'd4096));
      check($sformatf("rnd%0d_period", i), 32'(a_vcyc - a_vcyc_prev), 32'd136);
    end

    // En dropped during bit 5: frame completes, then the block parks in IDLE.
    wait_rises_a(5, "endrop_bit5");
    en_a = 1'b0;
    wait_valid_a("endrop");
    check("endrop_data", 32'(a_data), 32'h0ABC);
    check("endrop_ferr", 32'(a_err), 32'd0);
    check("endrop_csn_low", 32'(a_len), 32'd128);
    falls_snap = a_falls;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("endrop_idle_csn", 32'(csn_a), 32'd1);
    check("endrop_idle_sclk", 32'(sclk_a), 32'd1);
    check("endrop_no_new_frame", 32'(a_falls), 32'(falls_snap));

    // Reset during bit 9: the partial frame is dropped, then a fresh frame runs.
    frame_q.push_back(16'h0777);
    frame_q.push_back(16'h0C93);
    @(posedge clk);
    #1 en_a = 1'b1;
    wait_rises_a(9, "rst_bit9");
    vcnt_snap = a_vcnt;
    @(posedge clk);
    #1 rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("midrst_csn", 32'(csn_a), 32'd1);
    check("midrst_sclk", 32'(sclk_a), 32'd1);
    check("midrst_dataout", 32'(dout_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_no_valid", 32'(a_vcnt), 32'(vcnt_snap));
    wait_valid_a("after_rst");
    check("after_rst_data", 32'(a_data), 32'hC93);
    check("after_rst_ferr", 32'(a_err), 32'd0);
    check("after_rst_csn_low", 32'(a_len), 32'd128);
    check("after_rst_rises", 32'(a_rises_last), 32'd16);
    check("after_rst_one_valid", 32'(a_vcnt), 32'(vcnt_snap + 1));
    en_a = 1'b0;
    check("valid_single_cycle", 32'(a_dbl), 32'd0);

    // Instance B: CLK_DIV=2, QUIET_CYCLES=1.
    @(posedge clk);
    #1 en_b = 1'b1;
    wait_valid_b("b0");
    check("b0_data", 32'(b_data), 32'hA5A);
    check("b0_ferr", 32'(b_err), 32'd0);
    check("b0_csn_low", 32'(b_len), 32'd64);
    wait_valid_b("b1");
    en_b = 1'b0;
    check("b1_data", 32'(b_data), 32'hA5A);
    check("b1_csn_low", 32'(b_len), 32'd64);
    check("b1_period", 32'(b_vcyc - b_vcyc_prev), 32'd65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_deserializer.md
Name: adc_deserializer

Overview:
- SPI-style read master for a 12-bit serial ADC (ADCS7476/AD7476-class). It is the receive-side counterpart of the DAC serializer on the same board.
- Drives CSn and SCLK, samples SDATA, and assembles one 16-bit frame (4 leading zeros followed by 12 data bits, MSB first) into a parallel word with a one-cycle VALID strobe.
- Sits between the ADC pins and the sample-processing path. Runs continuous conversions while En is high.

Parameters:
- CLK_DIV, 4: Clk cycles per SCLK half-period (must be ≥2). SCLK = Clk/(2*CLK_DIV).
- FRAME_BITS, 16: SCLK cycles per conversion frame.
- DATA_BITS, 12: width of the result word, taken from the last DATA_BITS bits of the frame.
- QUIET_CYCLES, 8: minimum Clk cycles CSn is held high between frames (≥1).

Ports:
- Clk, in, 1: system clock.
- Rst, in, 1: reset, synchronous, active-high.
- En, in, 1: enables continuous conversion.
- SDATA, in, 1: serial data from the ADC. The ADC changes it after the SCLK falling edge.
- SCLK, out, 1: serial clock to the ADC. Idles high.
- CSn, out, 1: chip select, active-low. Idles high.
- DATAOUT, out, DATA_BITS: last received conversion result.
- VALID, out, 1: one-cycle strobe; DATAOUT and FRAME_ERR are new in this cycle.
- FRAME_ERR, out, 1: set when any leading (non-data) bit of the frame sampled 1.

Behaviour:
- Reset values (while Rst is high, and the cycle after): CSn=1, SCLK=1, DATAOUT=0, VALID=0, FRAME_ERR=0. State is IDLE; the divider, bit counter and shift register are cleared.
- Reset mid-frame aborts the frame immediately. The partial data is discarded, and no VALID is issued for it.
- FSM states: IDLE, SHIFT, QUIET.
- IDLE → SHIFT:
  - Taken on a Clk edge where En=1.
  - In the following cycle CSn=0, SCLK=1, and the divider and bit counter are at 0.
- SHIFT, per bit:
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SDATA is captured on the Clk edge that drives SCLK from 0 to 1, i.e. at the end of the low phase.
  - The shift register shifts left with SDATA entering at the LSB.
- Frame length:
  - CSn is low for exactly 2*CLK_DIV*FRAME_BITS Clk cycles (128 at defaults).
  - After the FRAME_BITS-th high phase, state → QUIET. CSn=1 and SCLK=1 in the same cycle.
- Frame completion (the first cycle of QUIET):
  - VALID=1.
  - DATAOUT = low DATA_BITS of the shift register.
  - FRAME_ERR = OR of the upper FRAME_BITS-DATA_BITS bits.
  - DATAOUT is updated even when FRAME_ERR=1.
  - VALID is high for exactly one cycle. DATAOUT and FRAME_ERR hold until the next VALID.
- QUIET:
  - Lasts QUIET_CYCLES cycles, counted from the VALID cycle.
  - On the last cycle: if En=1 → SHIFT (back-to-back frames; CSn period = 2*CLK_DIV*FRAME_BITS + QUIET_CYCLES); else → IDLE.
- En falling mid-frame: the frame completes normally (VALID issued), then the block goes to IDLE after QUIET.
- En toggling during QUIET: only its value on the last QUIET cycle matters.
- SCLK and CSn are registered outputs, glitch-free, with no combinational path from inputs.
- SDATA is used directly. The ADC is on the same board timing domain, so no synchronizer is added.

Decomposition:
- Shared package adc_dac_pkg holds:
  - constants DATA_BITS=12 and FRAME_BITS=16, shared with the DAC serializer;
  - the FSM enum type rx_state_t {IDLE, SHIFT, QUIET}.
- One sub-module, sclk_gen:
  - inputs: Clk, Rst, run;
  - outputs: SCLK plus single-cycle rise_stb/fall_stb strobes;
  - contains the CLK_DIV counter and holds SCLK high when run=0.
- The top level keeps the FSM, bit counter, shift register and output registers.

Test Plan:
- Defaults, En=1; the ADC model returns 4'b0000 followed by 12'hC93. Required: CSn low for 128 cycles, 16 SCLK rising edges, VALID one cycle with DATAOUT=12'hC93 and FRAME_ERR=0.
- Back-to-back frames with the model returning 12'h895 then 12'h589. Required: two VALIDs 136 cycles apart, DATAOUT=12'h895 then 12'h589, CSn high for exactly 8 cycles between frames.
- Model drives leading bits 4'b0100 with data 12'hFFF. Required: DATAOUT=12'hFFF and FRAME_ERR=1 with VALID. The next clean frame returns FRAME_ERR to 0.
- En dropped at bit 5 of a frame. Required: the frame completes with VALID and correct data, then CSn stays high and SCLK stays high (IDLE). No further frame starts until En=1.
- Rst asserted at bit 9 for 3 cycles. Required: in the cycle after Rst, CSn=1, SCLK=1, DATAOUT=0 and no VALID. With En=1 after reset, a fresh full 128-cycle frame returns correct data.
- CLK_DIV=2 and QUIET_CYCLES=1, data 12'hA5A. Required: CSn low for 64 cycles, DATAOUT=12'hA5A, frame period 65 cycles.
